// File: rtl/vector_register_file_mt.sv
// rtl/vector_register_file_mt.sv - multi-thread vector register file, 2R/1W masked, clear sequencer and bypass
// Each lane is its own DEPTH x LANE_WIDTH bank addressed by {thread, reg}.
module vector_register_file_mt #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_REGS    = 32,
    parameter int NUM_LANES   = 16,
    parameter int LANE_WIDTH  = 32,
    localparam int TW    = $clog2(NUM_THREADS),
    localparam int RW    = $clog2(NUM_REGS),
    localparam int VW    = NUM_LANES * LANE_WIDTH,
    localparam int DEPTH = NUM_THREADS * NUM_REGS
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 ready,
    input  logic                 rd1_en,
    input  logic [TW-1:0]        rd1_thread,
    input  logic [RW-1:0]        rd1_reg,
    output logic [VW-1:0]        rd1_value,
    input  logic                 rd2_en,
    input  logic [TW-1:0]        rd2_thread,
    input  logic [RW-1:0]        rd2_reg,
    output logic [VW-1:0]        rd2_value,
    input  logic                 wb_enable,
    input  logic [TW-1:0]        wb_thread,
    input  logic [RW-1:0]        wb_reg,
    input  logic [NUM_LANES-1:0] wb_mask,
    input  logic [VW-1:0]        wb_value
);
    localparam int AW = TW + RW;

    typedef enum logic {CLEAR, READY} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        clear_idx_q, clear_idx_d;
    logic [NUM_LANES-1:0] mem_we;
    logic [AW-1:0]        mem_addr;
    logic [VW-1:0]        mem_wdata;
    logic [AW-1:0]        rd1_addr, rd2_addr;
    logic                 rd1_fire, rd2_fire;
    logic [VW-1:0]        rd1_d, rd2_d;
    logic [VW-1:0]        rd1_q, rd2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= CLEAR;
            clear_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        mem_we      = '0;
        mem_addr    = {wb_thread, wb_reg};
        mem_wdata   = wb_value;
        if (state_q == CLEAR) begin
            // The sequencer owns the write port until every address is zeroed.
            mem_we      = '1;
            mem_addr    = clear_idx_q;
            mem_wdata   = '0;
            clear_idx_d = clear_idx_q + 1'b1;
            if (clear_idx_q == AW'(DEPTH - 1)) begin
                state_d = READY;
            end
        end else if (wb_enable) begin
            mem_we = wb_mask;
        end
    end

    assign ready    = (state_q == READY);
    assign rd1_addr = {rd1_thread, rd1_reg};
    assign rd2_addr = {rd2_thread, rd2_reg};
    assign rd1_fire = rd1_en && ready;
    assign rd2_fire = rd2_en && ready;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [LANE_WIDTH-1:0] bank [DEPTH];
        logic [LANE_WIDTH-1:0] wdata;

        assign wdata = mem_wdata[g*LANE_WIDTH +: LANE_WIDTH];

        always_ff @(posedge clk) begin
            if (mem_we[g]) begin
                bank[mem_addr] <= wdata;
            end
        end

        // Same-address write this cycle forwards only the lanes being written.
        assign rd1_d[g*LANE_WIDTH +: LANE_WIDTH] =
            (mem_we[g] && mem_addr == rd1_addr) ? wdata : bank[rd1_addr];
        assign rd2_d[g*LANE_WIDTH +: LANE_WIDTH] =
            (mem_we[g] && mem_addr == rd2_addr) ? wdata : bank[rd2_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd1_q <= '0;
            rd2_q <= '0;
        end else begin
            if (rd1_fire) begin
                rd1_q <= rd1_d;
            end
            if (rd2_fire) begin
                rd2_q <= rd2_d;
            end
        end
    end

    assign rd1_value = rd1_q;
    assign rd2_value = rd2_q;

endmodule

// File: tb/tb_vector_register_file_mt.sv
// tb/tb_vector_register_file_mt.sv - directed checks on default file plus reference-model run on a small instance
module tb_vector_register_file_mt;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ready;
    logic         rd1_en = 0, rd2_en = 0;
    logic [1:0]   rd1_thread = 0, rd2_thread = 0;
    logic [4:0]   rd1_reg = 0, rd2_reg = 0;
    logic [511:0] rd1_value, rd2_value;
    logic         wb_enable = 0;
    logic [1:0]   wb_thread = 0;
    logic [4:0]   wb_reg = 0;
    logic [15:0]  wb_mask = 0;
    logic [511:0] wb_value = 0;

    logic         s_ready;
    logic         s_rd1_en = 0, s_rd2_en = 0;
    logic [0:0]   s_rd1_thread = 0, s_rd2_thread = 0;
    logic [2:0]   s_rd1_reg = 0, s_rd2_reg = 0;
    logic [63:0]  s_rd1_value, s_rd2_value;
    logic         s_wb_enable = 0;
    logic [0:0]   s_wb_thread = 0;
    logic [2:0]   s_wb_reg = 0;
    logic [3:0]   s_wb_mask = 0;
    logic [63:0]  s_wb_value = 0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vector_register_file_mt dut (
        .clk(clk), .reset(reset), .ready(ready),
        .rd1_en(rd1_en), .rd1_thread(rd1_thread), .rd1_reg(rd1_reg), .rd1_value(rd1_value),
        .rd2_en(rd2_en), .rd2_thread(rd2_thread), .rd2_reg(rd2_reg), .rd2_value(rd2_value),
        .wb_enable(wb_enable), .wb_thread(wb_thread), .wb_reg(wb_reg),
        .wb_mask(wb_mask), .wb_value(wb_value)
    );

    vector_register_file_mt #(.NUM_THREADS(2), .NUM_REGS(8), .NUM_LANES(4), .LANE_WIDTH(16)) dut_small (
        .clk(clk), .reset(reset), .ready(s_ready),
        .rd1_en(s_rd1_en), .rd1_thread(s_rd1_thread), .rd1_reg(s_rd1_reg), .rd1_value(s_rd1_value),
        .rd2_en(s_rd2_en), .rd2_thread(s_rd2_thread), .rd2_reg(s_rd2_reg), .rd2_value(s_rd2_value),
        .wb_enable(s_wb_enable), .wb_thread(s_wb_thread), .wb_reg(s_wb_reg),
        .wb_mask(s_wb_mask), .wb_value(s_wb_value)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] fill(input logic [31:0] a, input logic [31:0] b, input logic [15:0] m);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = m[i] ? a : b;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        rd1_en = 0; rd2_en = 0; wb_enable = 0; wb_mask = '0;
    endtask

    task automatic wr(input logic [1:0] t, input logic [4:0] r, input logic [15:0] m, input logic [511:0] v);
        wb_enable = 1; wb_thread = t; wb_reg = r; wb_mask = m; wb_value = v;
    endtask

    task automatic rd(input int port, input logic [1:0] t, input logic [4:0] r);
        if (port == 1) begin rd1_en = 1; rd1_thread = t; rd1_reg = r; end
        else begin rd2_en = 1; rd2_thread = t; rd2_reg = r; end
    endtask

    // Counts edges from reset release until ready samples high; optionally writes T0 R0 mid-clear.
    task automatic wait_ready(input bit inject, output int n_big, output int n_small);
        n_big = 0; n_small = 0;
        for (int c = 1; c <= 300 && n_big == 0; c++) begin
            if (inject && c == 5) wr(2'd0, 5'd0, 16'hFFFF, fill(32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF));
            tick();
            idle();
            if (s_ready && n_small == 0) n_small = c;
            if (ready) n_big = c;
        end
    endtask

    logic [63:0] smem [16];
    logic [63:0] s_exp1, s_exp2;

    function automatic logic [63:0] s_read(input logic [3:0] a, input logic we, input logic [3:0] wa,
                                           input logic [3:0] m, input logic [63:0] wv);
        logic [63:0] v;
        v = smem[a];
        for (int i = 0; i < 4; i++) if (we && wa == a && m[i]) v[i*16 +: 16] = wv[i*16 +: 16];
        return v;
    endfunction

    initial begin
        int nb, ns;
        logic [6:0] av, bv;

        @(negedge clk); @(negedge clk);
        check("reset_ready", 512'(ready), 512'(0));
        check("reset_rd1", rd1_value, '0);
        check("reset_rd2", rd2_value, '0);
        reset = 0;
        wait_ready(0, nb, ns);
        check("clear_len", 512'(nb), 512'(128));
        check("small_clear_len", 512'(ns), 512'(16));

        for (int a = 0; a < 128; a++) begin
            av = a[6:0]; bv = 7'd127 - av;
            rd(1, av[6:5], av[4:0]);
            rd(2, bv[6:5], bv[4:0]);
            tick();
            check("zero_rd1", rd1_value, '0);
            check("zero_rd2", rd2_value, '0);
        end
        idle();

        wr(2'd2, 5'd5, 16'hFFFF, fill(32'hA5A5A5A5, 32'hA5A5A5A5, 16'hFFFF)); tick();
        wr(2'd2, 5'd5, 16'h00FF, fill(32'h11111111, 32'h11111111, 16'hFFFF)); tick();
        idle(); wr(2'd2, 5'd5, 16'h0000, fill(32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF)); tick();
        idle(); rd(1, 2'd2, 5'd5); rd(2, 2'd2, 5'd5); tick();
        check("masked_wr_p1", rd1_value, fill(32'h11111111, 32'hA5A5A5A5, 16'h00FF));
        check("masked_wr_p2", rd2_value, fill(32'h11111111, 32'hA5A5A5A5, 16'h00FF));

        idle(); wr(2'd1, 5'd3, 16'hFFFF, fill(32'h33333333, 32'h33333333, 16'hFFFF)); tick();
        wr(2'd0, 5'd3, 16'hFFFF, fill(32'h44444444, 32'h44444444, 16'hFFFF)); tick();
        wr(2'd1, 5'd3, 16'h0F0F, fill(32'h22222222, 32'h22222222, 16'hFFFF));
        rd(1, 2'd1, 5'd3); rd(2, 2'd0, 5'd3); tick();
        check("bypass_p1", rd1_value, fill(32'h22222222, 32'h33333333, 16'h0F0F));
        check("bypass_other_thread", rd2_value, fill(32'h44444444, 32'h44444444, 16'hFFFF));
        idle(); rd(2, 2'd1, 5'd3); tick();
        check("bypass_stored", rd2_value, fill(32'h22222222, 32'h33333333, 16'h0F0F));
        check("p1_hold_while_p2", rd1_value, fill(32'h22222222, 32'h33333333, 16'h0F0F));

        idle(); wr(2'd3, 5'd31, 16'hFFFF, fill(32'hDEADBEEF, 32'hDEADBEEF, 16'hFFFF)); tick();
        idle(); rd(1, 2'd3, 5'd31); tick();
        check("read_t3r31", rd1_value, fill(32'hDEADBEEF, 32'hDEADBEEF, 16'hFFFF));
        idle(); wr(2'd3, 5'd31, 16'hFFFF, '0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rd_hold", rd1_value, fill(32'hDEADBEEF, 32'hDEADBEEF, 16'hFFFF));
        end
        idle(); rd(1, 2'd3, 5'd31); tick();
        check("rd_reenable", rd1_value, '0);

        idle(); rd(1, 2'd2, 5'd5); tick(); idle();
        reset = 1; #1;
        check("async_reset_rd1", rd1_value, '0);
        check("async_reset_ready", 512'(ready), 512'(0));
        @(negedge clk); reset = 0;
        for (int i = 0; i < 60; i++) tick();
        reset = 1; #1;
        check("midclear_reset_ready", 512'(ready), 512'(0));
        @(negedge clk); reset = 0;
        wait_ready(1, nb, ns);
        check("restart_clear_len", 512'(nb), 512'(128));
        rd(1, 2'd0, 5'd0); rd(2, 2'd2, 5'd5); tick();
        check("clear_write_ignored", rd1_value, '0);
        check("reclear_t2r5", rd2_value, '0);
        idle();

        for (int i = 0; i < 16; i++) smem[i] = '0;
        s_exp1 = '0; s_exp2 = '0;
        for (int k = 0; k < 10000; k++) begin
            s_wb_enable  = 1'($urandom_range(0, 1));
            s_wb_thread  = 1'($urandom_range(0, 1));
            s_wb_reg     = 3'($urandom_range(0, 7));
            s_wb_mask    = 4'($urandom);
            s_wb_value   = {$urandom, $urandom};
            s_rd1_en     = ($urandom_range(0, 3) != 0);
            s_rd2_en     = ($urandom_range(0, 3) != 0);
            s_rd1_thread = 1'($urandom_range(0, 1));
            s_rd1_reg    = 3'($urandom_range(0, 7));
            s_rd2_thread = 1'($urandom_range(0, 1));
            s_rd2_reg    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin s_rd1_thread = s_wb_thread; s_rd1_reg = s_wb_reg; end
            if (s_rd1_en) s_exp1 = s_read({s_rd1_thread, s_rd1_reg}, s_wb_enable, {s_wb_thread, s_wb_reg}, s_wb_mask, s_wb_value);
            if (s_rd2_en) s_exp2 = s_read({s_rd2_thread, s_rd2_reg}, s_wb_enable, {s_wb_thread, s_wb_reg}, s_wb_mask, s_wb_value);
            if (s_wb_enable) smem[{s_wb_thread, s_wb_reg}] = s_read({s_wb_thread, s_wb_reg}, 1'b1, {s_wb_thread, s_wb_reg}, s_wb_mask, s_wb_value);
            tick();
            check("rand_rd1", 512'(s_rd1_value), 512'(s_exp1));
            check("rand_rd2", 512'(s_rd2_value), 512'(s_exp2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/vector_register_file_mt.md
Name: vector_register_file_mt

Overview:
Next-generation vector register file with per-hardware-thread register banks, a configurable lane count and lane width, and 2 read ports plus 1 lane-masked write port. Each lane is an independent memory bank. Adds three things the single-thread file lacked: deterministic zero-initialisation through a post-reset clear sequencer, write-to-read bypass, and read-enable hold. Sits between decode (read selects) and writeback (masked write), feeding operand values into the execute stage.

Parameters:
NUM_THREADS, 4, hardware threads; each has a private register set; power of two, >=2
NUM_REGS, 32, vector registers per thread; power of two
NUM_LANES, 16, 32-bit-style lanes per vector
LANE_WIDTH, 32, bits per lane
(localparams: TW=$clog2(NUM_THREADS), RW=$clog2(NUM_REGS), VW=NUM_LANES*LANE_WIDTH, DEPTH=NUM_THREADS*NUM_REGS)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
ready  output  1  1 = clear sequence done, file accepts reads/writes
rd1_en  input  1  read port 1 enable
rd1_thread  input  TW  read port 1 thread
rd1_reg  input  RW  read port 1 register
rd1_value  output  VW  read port 1 data; valid the cycle after the request
rd2_en, rd2_thread, rd2_reg, rd2_value  (same as port 1)
wb_enable  input  1  write enable
wb_thread  input  TW  write thread
wb_reg  input  RW  write register
wb_mask  input  NUM_LANES  lane write mask; bit i controls lane i (bits [i*LANE_WIDTH +: LANE_WIDTH])
wb_value  input  VW  write data

Behaviour:
- Storage address = {thread, reg}. Each lane owns its own DEPTH x LANE_WIDTH bank.
- FSM has two states: CLEAR and READY.
- While reset is high:
  - state=CLEAR, clear_idx=0, ready=0, rd1_value=0, rd2_value=0.
  - Asserting reset mid-operation, including mid-clear, returns to this condition asynchronously; the clear sequence restarts from 0.
- CLEAR state:
  - Each cycle writes 0 to address clear_idx in all lanes, then clear_idx increments.
  - After the cycle that writes DEPTH-1, state goes to READY; ready=1 from the next cycle.
  - ready therefore first samples high DEPTH cycles after the first clk edge with reset low (128 cycles at defaults).
  - Writes are ignored in CLEAR. Read enables are ignored and outputs stay 0.
- READY state, write:
  - If wb_enable=1, lane i is written with its wb_value slice iff wb_mask[i]=1.
  - Unmasked lanes keep their prior contents.
  - wb_mask=0 with wb_enable=1 is a no-op.
- READY state, read:
  - When rdN_en=1 at edge N, rdN_value holds that register's contents from edge N+1, i.e. one-cycle latency.
  - When rdN_en=0, rdN_value holds its previous value indefinitely.
- Bypass (replaces the old undefined-on-collision behaviour):
  - Condition: read and write hit the same thread/reg in the same cycle.
  - Lanes with wb_mask=1 return the new wb_value. All other lanes return the previously stored value.
  - Different thread with the same reg number is not a collision; the read returns the stored value of its own thread.
- Both read ports may address the same or different registers in the same cycle, with independent results.
- No other state. The FSM never returns to CLEAR except via reset.

Test Plan:
- Reset, then release -> ready=0 for exactly 128 cycles (defaults), then 1. Reading every {thread, reg} returns 0 on both ports. Pulsing reset at cycle 60 of the clear restarts the 128-cycle count.
- T2 R5 written with 0xA5A5A5A5 in all lanes, mask 0xFFFF. Next cycle, write T2 R5 with 0x11111111, mask 0x00FF. Read T2 R5 -> lanes 0-7 = 0x11111111, lanes 8-15 = 0xA5A5A5A5.
- Same-cycle write T1 R3 = 0x22222222 mask 0x0F0F, plus read T1 R3 on port 1 (old value 0x33333333) -> next cycle lanes {0-3, 8-11} = 0x22222222, rest = 0x33333333. Port 2 reading T0 R3 in the same cycle -> its stored value, unaffected by the write.
- Read T3 R31 on port 1 (value 0xDEADBEEF), then hold rd1_en=0 for 5 cycles while writing T3 R31 = 0 -> rd1_value stays 0xDEADBEEF. Re-enabling rd1_en -> 0 the following cycle.
- During CLEAR, issue a write of T0 R0 = 0xFFFFFFFF -> after ready, T0 R0 reads 0.
- Parameter sweep: NUM_THREADS=2, NUM_REGS=8, NUM_LANES=4, LANE_WIDTH=16 -> clear takes 16 cycles. A randomised write/read/bypass run matches a reference memory model for 10k cycles.
